glitch_sequencer: RTL and testbench
===================================

Name: glitch_sequencer

Overview:
- Parametrised successor to the single-shot glitch controller.
- Pops command words from the command FIFO and drives the glitch core's enable and mode inputs (glitch_en, glitch_mode).
- Adds a per-command external trigger wait, a per-command repeat count, an abort input, generic field widths and a pulse counter.
- Sits between the host command FIFO and glitch_core, in the clk_in domain.

Parameters:
- DELAY_W, 16, width of the delay/gap field in clk_in cycles
- WIDTH_W, 8, width of the pulse-width field in clk_in cycles
- REP_W, 8, width of the repeat field
- MODE_W, 7, width of the mode field passed to the core
- PCNT_W, 16, width of the emitted-pulse counter
- CMD_W, DELAY_W+WIDTH_W+REP_W+MODE_W+1, command word width (derived; do not override)

Ports:
- clk_in  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- fifo_in  in  CMD_W  command word; valid the cycle after fifo_re
- fifo_empty  in  1  FIFO empty flag
- fifo_re  out  1  FIFO read strobe, one cycle per word
- en  in  1  level; commands are consumed only while high
- abort  in  1  level; kills the current command
- trig_in  in  1  asynchronous external trigger
- glitch_en  out  1  enable to glitch_core
- glitch_mode  out  MODE_W  mode to glitch_core, latched per command
- ready  out  1  high when state==IDLE and en==0
- busy  out  1  high when state!=IDLE
- pulse_cnt  out  PCNT_W  pulses started since reset; saturating

Behaviour:
- Command fields, MSB to LSB: delay D[DELAY_W], width W[WIDTH_W], repeat R[REP_W], mode M[MODE_W], trig flag T[1] at bit 0.
- Reset: state=IDLE, fifo_re=0, glitch_en=0, glitch_mode=0, pulse_cnt=0, all counters 0, trigger synchroniser cleared.
- States: IDLE, READ, TRIG, DELAY, WIDTH.
- IDLE: if en && !fifo_empty, fifo_re=1 for one cycle, then go to READ.
- READ (cycle r): latch D, W, R, M, T into registers; clear counters; glitch_mode<=M; then branch in this order:
  - W==0: command is a no-op, except that a set T still waits for a trigger.
  - T==1: go to TRIG.
  - D==0: glitch_en<=1, go to WIDTH.
  - else: go to DELAY.
- trig_in: 2-FF synchroniser plus edge register. Edge pulse is 3–4 cycles after the raw rising edge. Only edges seen while in TRIG count; there is no buffering of earlier edges.
- TRIG: on the edge-pulse cycle t, branch exactly as READ does on D and W.
- DELAY: D cycles with glitch_en=0. On the last cycle, glitch_en<=1 and go to WIDTH.
- glitch_en timing: high during cycles s+1+D .. s+D+W, where s = r (T=0) or s = t (T=1).
- WIDTH: W cycles with glitch_en=1.
  - pulse_cnt increments once per pulse, on entry to WIDTH; it saturates at all-ones.
  - On the last WIDTH cycle, glitch_en<=0.
  - If pulses emitted < R+1: go to DELAY; D acts as the inter-pulse gap, so period = D+W.
  - With D==0 and R>0, the next pulse follows immediately: glitch_en stays high continuously for (R+1)*W cycles, and pulse_cnt still adds R+1.
- Repeat field: R=0 means one pulse; R=255 (default width) means 256 pulses.
- Command end (last WIDTH cycle, last DELAY cycle when W==0, or the READ/TRIG no-op cycle):
  - if en && !fifo_empty, assert fifo_re in the same cycle and go to READ, giving zero idle cycles between commands;
  - else go to IDLE.
- All counter comparisons use the latched fields, never live fifo_in.
- en dropping mid-command: the current command completes, including repeats; then IDLE.
- abort=1 in any state: next cycle state=IDLE, glitch_en=0, no fifo_re. The FIFO is not flushed and pulse_cnt is kept. abort has priority over all other transitions.
- Simultaneous abort and trigger edge: abort wins.
- rst mid-pulse: glitch_en=0 on the next cycle.

Test Plan:
- Delay/width: D=3,W=2,R=0,T=0,M=5 → glitch_en high for exactly cycles r+4..r+5; glitch_mode=5; pulse_cnt=1; IDLE when FIFO empty.
- Repeats: D=2,W=3,R=2 → three 3-cycle pulses separated by 2 low cycles; pulse_cnt=3.
- Back-to-back commands: {D=0,W=1} then {D=1,W=1} → fifo_re in the last WIDTH cycle; second pulse starts 2 cycles after the first ends; no IDLE visit.
- Trigger: T=1,D=0,W=4; trig_in rises 20 cycles later → glitch_en high 4 cycles starting one cycle after the sync edge pulse; no pulse before the trigger.
- Abort: abort asserted mid-WIDTH with R=5 → glitch_en low the next cycle; state IDLE; fifo_re stays 0; pulse_cnt frozen.
- Zero-width command: W=0,D=10 then {D=0,W=2} → no pulse for 10 cycles, then one 2-cycle pulse; ready=1 after en is deasserted.

Source files
------------

// File: rtl/glitch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : glitch_sequencer
//  Description : Pops command words from the host command FIFO and sequences
//                glitch_core's enable/mode inputs: optional external-trigger
//                wait, programmable delay, pulse width, repeat count, abort,
//                and a saturating count of pulses started.
//  Revision    : 1.0 - initial release
// ============================================================================
module glitch_sequencer #(
    parameter int DELAY_W = 16,
    parameter int WIDTH_W = 8,
    parameter int REP_W   = 8,
    parameter int MODE_W  = 7,
    parameter int PCNT_W  = 16,
    parameter int CMD_W   = DELAY_W + WIDTH_W + REP_W + MODE_W + 1
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic [CMD_W-1:0]  fifo_in,
    input  logic              fifo_empty,
    output logic              fifo_re,
    input  logic              en,
    input  logic              abort,
    input  logic              trig_in,
    output logic              glitch_en,
    output logic [MODE_W-1:0] glitch_mode,
    output logic              ready,
    output logic              busy,
    output logic [PCNT_W-1:0] pulse_cnt
);

    // Command word layout, LSB upwards: T, M, R, W, D
    localparam int c_M_LSB = 1;
    localparam int c_R_LSB = c_M_LSB + MODE_W;
    localparam int c_W_LSB = c_R_LSB + REP_W;
    localparam int c_D_LSB = c_W_LSB + WIDTH_W;
    // One shared counter times both the delay/gap and the pulse width
    localparam int c_CNT_W = (DELAY_W > WIDTH_W) ? DELAY_W : WIDTH_W;

    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [REP_W:0]     c_PULSE_ONE = (REP_W + 1)'(1);
    localparam logic [PCNT_W-1:0]  c_PCNT_ONE  = PCNT_W'(1);
    localparam logic [PCNT_W-1:0]  c_PCNT_MAX  = {PCNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_TRIG  = 3'd2,
        S_DELAY = 3'd3,
        S_WIDTH = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DELAY_W-1:0]  r_d;
    logic [WIDTH_W-1:0]  r_w;
    logic [REP_W-1:0]    r_r;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [REP_W:0]      r_pulses;      // pulses emitted by the current command
    logic [REP_W:0]      w_pulses_nxt;
    logic                r_glitch_en;
    logic                w_glitch_en_nxt;
    logic [MODE_W-1:0]   r_mode;
    logic [PCNT_W-1:0]   r_pcnt;
    logic                r_trig_s1;
    logic                r_trig_s2;
    logic                r_trig_s3;
    logic                r_trig_edge;

    logic                w_fifo_re;
    logic                w_pcnt_inc;
    logic                w_load;
    logic                w_start;       // begin delay/width phase of a command
    logic                w_end;         // command finished this cycle
    logic                w_d_last;
    logic                w_w_last;
    logic                w_more;

    logic                w_cmd_t;
    logic [MODE_W-1:0]   w_cmd_m;
    logic [REP_W-1:0]    w_cmd_r;
    logic [WIDTH_W-1:0]  w_cmd_w;
    logic [DELAY_W-1:0]  w_cmd_d;
    logic [DELAY_W-1:0]  w_br_d;
    logic [WIDTH_W-1:0]  w_br_w;

    assign w_cmd_t = fifo_in[0];
    assign w_cmd_m = fifo_in[c_R_LSB-1:c_M_LSB];
    assign w_cmd_r = fifo_in[c_W_LSB-1:c_R_LSB];
    assign w_cmd_w = fifo_in[c_D_LSB-1:c_W_LSB];
    assign w_cmd_d = fifo_in[CMD_W-1:c_D_LSB];

    // READ branches on the word being latched, TRIG on the latched copy
    assign w_br_d = (r_state == S_READ) ? w_cmd_d : r_d;
    assign w_br_w = (r_state == S_READ) ? w_cmd_w : r_w;

    assign w_d_last = ((r_cnt + c_CNT_ONE) == c_CNT_W'(r_d));
    assign w_w_last = ((r_cnt + c_CNT_ONE) == c_CNT_W'(r_w));
    assign w_more   = (r_pulses <= {1'b0, r_r});

    assign fifo_re     = w_fifo_re;
    assign glitch_en   = r_glitch_en;
    assign glitch_mode = r_mode;
    assign pulse_cnt   = r_pcnt;
    assign ready       = (r_state == S_IDLE) && !en;
    assign busy        = (r_state != S_IDLE);

    // Trigger input: two-flop synchroniser, history flop and registered edge
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_trig_s1   <= 1'b0;
            r_trig_s2   <= 1'b0;
            r_trig_s3   <= 1'b0;
            r_trig_edge <= 1'b0;
        end else begin
            r_trig_s1   <= trig_in;
            r_trig_s2   <= r_trig_s1;
            r_trig_s3   <= r_trig_s2;
            r_trig_edge <= r_trig_s2 & ~r_trig_s3;
        end
    end

    // Next-state, counter updates, FIFO strobe and pulse bookkeeping
    always_comb begin
        w_state_nxt     = r_state;
        w_fifo_re       = 1'b0;
        w_cnt_nxt       = r_cnt;
        w_pulses_nxt    = r_pulses;
        w_glitch_en_nxt = r_glitch_en;
        w_pcnt_inc      = 1'b0;
        w_load          = 1'b0;
        w_start         = 1'b0;
        w_end           = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (en && !fifo_empty) begin
                    w_fifo_re   = 1'b1;
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_load       = 1'b1;
                w_cnt_nxt    = '0;
                w_pulses_nxt = '0;
                if (w_cmd_t) begin
                    w_state_nxt = S_TRIG;
                end else begin
                    w_start = 1'b1;
                end
            end
            S_TRIG: begin
                if (r_trig_edge) begin
                    w_start = 1'b1;
                end
            end
            S_DELAY: begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (w_d_last) begin
                    w_cnt_nxt = '0;
                    if (r_w == '0) begin
                        w_end = 1'b1;
                    end else begin
                        w_state_nxt     = S_WIDTH;
                        w_glitch_en_nxt = 1'b1;
                        w_pulses_nxt    = r_pulses + c_PULSE_ONE;
                        w_pcnt_inc      = 1'b1;
                    end
                end
            end
            S_WIDTH: begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (w_w_last) begin
                    w_cnt_nxt = '0;
                    if (!w_more) begin
                        w_glitch_en_nxt = 1'b0;
                        w_end           = 1'b1;
                    end else if (r_d == '0) begin
                        // Zero gap: next pulse abuts this one, enable stays high
                        w_pulses_nxt = r_pulses + c_PULSE_ONE;
                        w_pcnt_inc   = 1'b1;
                    end else begin
                        w_glitch_en_nxt = 1'b0;
                        w_state_nxt     = S_DELAY;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_start) begin
            w_cnt_nxt    = '0;
            w_pulses_nxt = '0;
            if (w_br_w == '0) begin
                // No pulse; a non-zero delay is still waited out
                if (w_br_d == '0) begin
                    w_end = 1'b1;
                end else begin
                    w_state_nxt = S_DELAY;
                end
            end else if (w_br_d == '0) begin
                w_state_nxt     = S_WIDTH;
                w_glitch_en_nxt = 1'b1;
                w_pulses_nxt    = c_PULSE_ONE;
                w_pcnt_inc      = 1'b1;
            end else begin
                w_state_nxt = S_DELAY;
            end
        end

        // Fetch the next word in the same cycle so commands run gap-free
        if (w_end) begin
            w_glitch_en_nxt = 1'b0;
            if (en && !fifo_empty) begin
                w_fifo_re   = 1'b1;
                w_state_nxt = S_READ;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end

        if (abort) begin
            w_state_nxt     = S_IDLE;
            w_glitch_en_nxt = 1'b0;
            w_fifo_re       = 1'b0;
            w_pcnt_inc      = 1'b0;
            w_load          = 1'b0;
        end

        if (rst) begin
            w_fifo_re = 1'b0;
        end
    end

    // State, counters, latched command fields and the pulse counter
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_d         <= '0;
            r_w         <= '0;
            r_r         <= '0;
            r_cnt       <= '0;
            r_pulses    <= '0;
            r_glitch_en <= 1'b0;
            r_mode      <= '0;
            r_pcnt      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_pulses    <= w_pulses_nxt;
            r_glitch_en <= w_glitch_en_nxt;
            if (w_load) begin
                r_d    <= w_cmd_d;
                r_w    <= w_cmd_w;
                r_r    <= w_cmd_r;
                r_mode <= w_cmd_m;
            end
            if (w_pcnt_inc && (r_pcnt != c_PCNT_MAX)) begin
                r_pcnt <= r_pcnt + c_PCNT_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_glitch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_glitch_sequencer
//  Description : Self-checking bench for glitch_sequencer. A FIFO model feeds
//                command words; expected waveforms are derived per command
//                from its delay/width/repeat arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_glitch_sequencer;

    localparam int CMD_W = 40;

    logic             clk_in;
    logic             rst;
    logic [CMD_W-1:0] fifo_in;
    logic             fifo_empty;
    logic             fifo_re;
    logic             en;
    logic             abort;
    logic             trig_in;
    logic             glitch_en;
    logic [6:0]       glitch_mode;
    logic             ready;
    logic             busy;
    logic [15:0]      pulse_cnt;

    glitch_sequencer dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .fifo_in     (fifo_in),
        .fifo_empty  (fifo_empty),
        .fifo_re     (fifo_re),
        .en          (en),
        .abort       (abort),
        .trig_in     (trig_in),
        .glitch_en   (glitch_en),
        .glitch_mode (glitch_mode),
        .ready       (ready),
        .busy        (busy),
        .pulse_cnt   (pulse_cnt)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    // FIFO model: word appears on fifo_in the cycle after the read strobe
    logic [CMD_W-1:0] cmd_mem [0:127];
    int               n_cmds = 0;
    int               rd_ptr = 0;
    assign fifo_empty = (rd_ptr >= n_cmds);

    initial fifo_in = '0;
    always @(posedge clk_in) begin
        if (fifo_re && (rd_ptr < n_cmds)) begin
            fifo_in <= cmd_mem[rd_ptr];
            rd_ptr  <= rd_ptr + 1;
        end
    end

    // Reference state carried across scenarios
    int         exp_pcnt     = 0;
    logic [6:0] exp_mode_cur = '0;

    // Command list for the sequence model
    int m_d [0:15];
    int m_w [0:15];
    int m_r [0:15];
    int m_m [0:15];
    int m_n;

    bit         ex_en   [0:1023];
    bit         ex_re   [0:1023];
    bit         ex_busy [0:1023];
    logic [6:0] ex_mode [0:1023];

    function automatic logic [CMD_W-1:0] mk(input int d, input int w, input int r,
                                            input int m, input int t);
        return {16'(d), 8'(w), 8'(r), 7'(m), 1'(t)};
    endfunction

    // Untriggered command list: expected timeline built from pulse arithmetic,
    // then the DUT is run with en held high and compared every cycle.
    task automatic run_seq(input string name);
        int s;
        int e;
        int last_e;
        s      = 1;
        e      = 0;
        last_e = 0;
        for (int c = 0; c < 1024; c++) begin
            ex_en[c]   = 1'b0;
            ex_re[c]   = 1'b0;
            ex_busy[c] = 1'b0;
            ex_mode[c] = exp_mode_cur;
        end
        ex_re[0] = 1'b1;
        for (int i = 0; i < m_n; i++) begin
            for (int c = s + 1; c < 1024; c++) ex_mode[c] = 7'(m_m[i]);
            if (m_w[i] > 0) begin
                for (int k = 0; k <= m_r[i]; k++)
                    for (int j = 1; j <= m_w[i]; j++)
                        ex_en[s + m_d[i] + j + k * (m_d[i] + m_w[i])] = 1'b1;
                exp_pcnt += m_r[i] + 1;
                e = s + (m_r[i] + 1) * (m_d[i] + m_w[i]);
            end else begin
                e = s + m_d[i];
            end
            for (int c = s; c <= e; c++) ex_busy[c] = 1'b1;
            if (i < m_n - 1) begin
                ex_re[e] = 1'b1;
                s = e + 1;
            end
            last_e = e;
        end
        exp_mode_cur = 7'(m_m[m_n - 1]);
        for (int i = 0; i < m_n; i++) begin
            cmd_mem[n_cmds] = mk(m_d[i], m_w[i], m_r[i], m_m[i], 0);
            n_cmds++;
        end
        @(posedge clk_in);
        #1 en = 1'b1;
        for (int c = 0; c <= last_e + 3; c++) begin
            @(negedge clk_in);
            n_checks++;
            if (glitch_en !== ex_en[c])
                $display("FAIL %s glitch_en cycle %0d: got %b expected %b", name, c, glitch_en, ex_en[c]);
            else n_pass++;
            n_checks++;
            if (fifo_re !== ex_re[c])
                $display("FAIL %s fifo_re cycle %0d: got %b expected %b", name, c, fifo_re, ex_re[c]);
            else n_pass++;
            n_checks++;
            if (busy !== ex_busy[c])
                $display("FAIL %s busy cycle %0d: got %b expected %b", name, c, busy, ex_busy[c]);
            else n_pass++;
            n_checks++;
            if (glitch_mode !== ex_mode[c])
                $display("FAIL %s glitch_mode cycle %0d: got %0d expected %0d", name, c, glitch_mode, ex_mode[c]);
            else n_pass++;
        end
        n_checks++;
        if (pulse_cnt !== 16'(exp_pcnt))
            $display("FAIL %s pulse_cnt: got %0d expected %0d", name, pulse_cnt, 16'(exp_pcnt));
        else n_pass++;
        en = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if (ready !== 1'b1)
            $display("FAIL %s ready_after_en_low: got %b expected 1", name, ready);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; abort = 1'b0; trig_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1 rst = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if (glitch_en !== 1'b0) $display("FAIL reset_glitch_en: got %b expected 0", glitch_en); else n_pass++;
        n_checks++;
        if (fifo_re !== 1'b0) $display("FAIL reset_fifo_re: got %b expected 0", fifo_re); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++;
        if (ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready); else n_pass++;
        n_checks++;
        if (pulse_cnt !== 16'd0) $display("FAIL reset_pulse_cnt: got %0d expected 0", pulse_cnt); else n_pass++;
        n_checks++;
        if (glitch_mode !== 7'd0) $display("FAIL reset_glitch_mode: got %0d expected 0", glitch_mode); else n_pass++;
    endtask

    task automatic test_delay_width();
        m_n = 1;
        m_d[0] = 3; m_w[0] = 2; m_r[0] = 0; m_m[0] = 5;
        run_seq("delay_width");
    endtask

    task automatic test_repeats();
        m_n = 1;
        m_d[0] = 2; m_w[0] = 3; m_r[0] = 2; m_m[0] = 33;
        run_seq("repeats");
    endtask

    task automatic test_repeat_max();
        m_n = 1;
        m_d[0] = 0; m_w[0] = 1; m_r[0] = 255; m_m[0] = 127;
        run_seq("repeat_max");
    endtask

    task automatic test_back_to_back();
        m_n = 2;
        m_d[0] = 0; m_w[0] = 1; m_r[0] = 0; m_m[0] = 9;
        m_d[1] = 1; m_w[1] = 1; m_r[1] = 0; m_m[1] = 10;
        run_seq("back_to_back");
    endtask

    task automatic test_zero_width();
        m_n = 3;
        m_d[0] = 10; m_w[0] = 0; m_r[0] = 3; m_m[0] = 17;
        m_d[1] = 0;  m_w[1] = 2; m_r[1] = 0; m_m[1] = 18;
        m_d[2] = 0;  m_w[2] = 0; m_r[2] = 0; m_m[2] = 19;
        run_seq("zero_width");
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            m_n = int'($urandom_range(1, 4));
            for (int i = 0; i < m_n; i++) begin
                m_d[i] = int'($urandom_range(0, 5));
                m_w[i] = int'($urandom_range(0, 4));
                m_r[i] = int'($urandom_range(0, 3));
                m_m[i] = int'($urandom_range(0, 127));
            end
            run_seq($sformatf("random%0d", it));
        end
    endtask

    task automatic test_trigger();
        int         bad;
        int         first;
        int         hi;
        logic [6:0] m;
        m = 7'($urandom_range(1, 127));
        // Edge while idle must not be remembered for a later command
        trig_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1 trig_in = 1'b0;
        repeat (6) @(posedge clk_in);
        cmd_mem[n_cmds] = mk(0, 4, 0, m, 1);
        n_cmds++;
        #1 en = 1'b1;
        bad = 0;
        for (int c = 0; c < 22; c++) begin
            @(negedge clk_in);
            if (glitch_en !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL trig_no_early_pulse: got %0d high cycles expected 0", bad); else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL trig_waiting_busy: got %b expected 1", busy); else n_pass++;
        trig_in = 1'b1;
        first = -1;
        for (int c = 1; c <= 8 && first < 0; c++) begin
            @(negedge clk_in);
            if (glitch_en === 1'b1) first = c;
        end
        n_checks++;
        if (first < 4 || first > 5)
            $display("FAIL trig_latency: got %0d cycles expected 4..5", first);
        else n_pass++;
        hi = (first > 0) ? 1 : 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in);
            if (glitch_en === 1'b1) hi++;
        end
        n_checks++;
        if (hi != 4) $display("FAIL trig_width: got %0d high cycles expected 4", hi); else n_pass++;
        exp_pcnt++;
        exp_mode_cur = m;
        n_checks++;
        if (pulse_cnt !== 16'(exp_pcnt)) $display("FAIL trig_pulse_cnt: got %0d expected %0d", pulse_cnt, 16'(exp_pcnt)); else n_pass++;
        n_checks++;
        if (glitch_mode !== m) $display("FAIL trig_mode: got %0d expected %0d", glitch_mode, m); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL trig_done_idle: got busy %b expected 0", busy); else n_pass++;
        trig_in = 1'b0;
        en = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_abort();
        int         first;
        int         seen;
        int         done;
        logic [6:0] ma;
        logic [6:0] mb;
        ma = 7'($urandom_range(0, 63));
        mb = 7'($urandom_range(64, 127));
        cmd_mem[n_cmds] = mk(1, 6, 5, ma, 0); n_cmds++;
        cmd_mem[n_cmds] = mk(0, 1, 0, mb, 0); n_cmds++;
        @(posedge clk_in);
        #1 en = 1'b1;
        first = -1;
        for (int c = 0; c < 20 && first < 0; c++) begin
            @(negedge clk_in);
            if (glitch_en === 1'b1) first = c;
        end
        n_checks++;
        if (first != 3) $display("FAIL abort_first_pulse_cycle: got %0d expected 3", first); else n_pass++;
        exp_pcnt++;
        exp_mode_cur = ma;
        @(negedge clk_in);
        @(negedge clk_in);
        abort = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in);
            n_checks++;
            if (glitch_en !== 1'b0) $display("FAIL abort_glitch_en cycle %0d: got %b expected 0", c, glitch_en); else n_pass++;
            n_checks++;
            if (busy !== 1'b0) $display("FAIL abort_busy cycle %0d: got %b expected 0", c, busy); else n_pass++;
            n_checks++;
            if (fifo_re !== 1'b0) $display("FAIL abort_fifo_re cycle %0d: got %b expected 0", c, fifo_re); else n_pass++;
        end
        n_checks++;
        if (pulse_cnt !== 16'(exp_pcnt)) $display("FAIL abort_pulse_cnt_frozen: got %0d expected %0d", pulse_cnt, 16'(exp_pcnt)); else n_pass++;
        abort = 1'b0;
        // The queued word survives the abort and runs now
        seen = 0;
        done = 0;
        for (int c = 0; c < 30 && done == 0; c++) begin
            @(negedge clk_in);
            if (busy === 1'b1) seen = 1;
            else if (seen != 0) done = 1;
        end
        n_checks++;
        if (done != 1) $display("FAIL abort_next_cmd_done: got %0d expected 1", done); else n_pass++;
        exp_pcnt++;
        exp_mode_cur = mb;
        n_checks++;
        if (pulse_cnt !== 16'(exp_pcnt)) $display("FAIL abort_next_pulse_cnt: got %0d expected %0d", pulse_cnt, 16'(exp_pcnt)); else n_pass++;
        n_checks++;
        if (glitch_mode !== mb) $display("FAIL abort_next_mode: got %0d expected %0d", glitch_mode, mb); else n_pass++;
        en = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic test_reset_mid_pulse();
        int first;
        cmd_mem[n_cmds] = mk(0, 8, 0, 77, 0); n_cmds++;
        @(posedge clk_in);
        #1 en = 1'b1;
        first = -1;
        for (int c = 0; c < 20 && first < 0; c++) begin
            @(negedge clk_in);
            if (glitch_en === 1'b1) first = c;
        end
        n_checks++;
        if (first != 2) $display("FAIL rstmid_pulse_start: got %0d expected 2", first); else n_pass++;
        @(negedge clk_in);
        rst = 1'b1;
        @(negedge clk_in);
        n_checks++;
        if (glitch_en !== 1'b0) $display("FAIL rstmid_glitch_en: got %b expected 0", glitch_en); else n_pass++;
        n_checks++;
        if (pulse_cnt !== 16'd0) $display("FAIL rstmid_pulse_cnt: got %0d expected 0", pulse_cnt); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        rst = 1'b0;
        en  = 1'b0;
        exp_pcnt = 0;
        exp_mode_cur = '0;
        @(negedge clk_in);
    endtask

    initial begin
        test_reset();
        test_delay_width();
        test_repeats();
        test_back_to_back();
        test_zero_width();
        test_repeat_max();
        test_trigger();
        test_abort();
        test_random();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
